// File: rtl/nios_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// nios_system_sysid_checker
//
// Reads the system ID word (address 0) and the build timestamp word
// (address 1) from an Avalon-MM sysid slave and compares them with the values
// this build expects. A check starts by itself once reset is released. After
// that, a start pulse in IDLE or DONE starts the check again.
//
// Optional feature: define SYSID_CHECK_TIMEOUT_EN to add a per-phase
// watchdog. The watchdog aborts a check when a request or response phase
// lasts TIMEOUT_CYCLES cycles. When the macro is not defined there is no
// watchdog, timeout is tied to 0 and the checker waits on the slave
// indefinitely.
//
// Parameters
//   EXPECTED_ID         system ID the hardware must report
//   EXPECTED_TIMESTAMP  build timestamp the hardware must report
//   TIMEOUT_CYCLES      watchdog limit per phase, 1..65535
//
// Ports
//   clock              in   sole clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   start              in   single-cycle pulse requesting a new check
//   avm_address        out  word address: 0 = ID, 1 = timestamp
//   avm_read           out  read strobe
//   avm_readdata       in   [31:0] read data
//   avm_waitrequest    in   slave stall
//   avm_readdatavalid  in   avm_readdata valid this cycle
//   sysid_value        out  [31:0] captured ID word
//   timestamp_value    out  [31:0] captured timestamp word
//   busy               out  check in progress
//   done               out  sticky, check finished
//   match              out  both words equal their expected values (valid with done)
//   timeout            out  sticky, check aborted by the watchdog
// -----------------------------------------------------------------------------
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1478524007,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic [31:0] sysid_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    RSP_ID,
    REQ_TS,
    RSP_TS,
    DONE
  } state_t;

  state_t state;

  // avm_read is registered, so acceptance depends only on the stall input
  // for the current cycle.
  logic accept;
  assign accept = avm_read & ~avm_waitrequest;

  // wd_fire aborts the current phase. It is constant 0 without the watchdog.
  logic wd_fire;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        progress;

  // A phase makes progress when its request is accepted or its response
  // arrives. The counter restarts at that point, so every phase is timed
  // from its own first cycle.
  always_comb begin
    progress = 1'b0;
    case (state)
      REQ_ID, REQ_TS: progress = accept;
      RSP_ID, RSP_TS: progress = avm_readdatavalid;
      default:        progress = 1'b0;
    endcase
  end

  // busy is high exactly in the REQ/RSP states, so it gates the watchdog.
  assign wd_fire = busy & ~progress & (wd_cnt == WD_LAST);
  assign timeout = timeout_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end else if (start && (state == IDLE || state == DONE)) begin
        timeout_q <= 1'b0;
      end
      if (!busy || progress || wd_fire) begin
        wd_cnt <= 16'd0;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      avm_read        <= 1'b0;
      avm_address     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
      sysid_value     <= 32'h0;
      timestamp_value <= 32'h0;
    end else if (wd_fire) begin
      state    <= DONE;
      avm_read <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b1;
      match    <= 1'b0;
    end else begin
      case (state)
        // IDLE is entered only through reset. Leaving it at once gives the
        // check that runs by itself after reset. DONE waits for start.
        IDLE, DONE: begin
          if (state == IDLE || start) begin
            state       <= REQ_ID;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            match       <= 1'b0;
          end
        end
        REQ_ID: begin
          if (accept) begin
            state    <= RSP_ID;
            avm_read <= 1'b0;
          end
        end
        RSP_ID: begin
          if (avm_readdatavalid) begin
            sysid_value <= avm_readdata;
            state       <= REQ_TS;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
          end
        end
        REQ_TS: begin
          if (accept) begin
            state    <= RSP_TS;
            avm_read <= 1'b0;
          end
        end
        RSP_TS: begin
          if (avm_readdatavalid) begin
            timestamp_value <= avm_readdata;
            state           <= DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            // sysid_value was captured in an earlier cycle. The timestamp is
            // compared directly from the bus in the same cycle it is loaded.
            match           <= (sysid_value == EXPECTED_ID) &&
                               (avm_readdata == EXPECTED_TIMESTAMP);
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_nios_system_sysid_checker
//
// Directed bench for nios_system_sysid_checker. A small Avalon-MM slave model
// answers the reads. It can stall ID reads, suppress responses, and inject a
// stray readdatavalid pulse. The stimulus is one linear sequence of steps, and
// every step checks the DUT against values worked out by hand.
// -----------------------------------------------------------------------------
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1478524007;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata      = 32'h0;
  logic        avm_waitrequest   = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] sysid_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        match;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // slave configuration (written by the stimulus only)
  logic [31:0] id_data   = 32'h0;
  logic [31:0] ts_data   = TS_GOOD;
  int          stall_id  = 0;
  logic        id_rsp_en = 1'b1;
  logic        ts_rsp_en = 1'b1;
  int          stray_req = 0;

  // slave state (written by the slave model only)
  int   stray_done = 0;
  int   stall_cnt  = 0;
  int   stall_seen = 0;
  int   stall_bad  = 0;
  int   id_accepts = 0;
  int   ts_accepts = 0;
  logic rsp_due    = 1'b0;
  logic rsp_addr   = 1'b0;

  always #5 clock = ~clock;

  nios_system_sysid_checker #(
    .EXPECTED_ID       (32'h0000_0000),
    .EXPECTED_TIMESTAMP(TS_GOOD),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .sysid_value      (sysid_value),
    .timestamp_value  (timestamp_value),
    .busy             (busy),
    .done             (done),
    .match            (match),
    .timeout          (timeout)
  );

  // Slave model. It drives on the falling edge, so its inputs are stable
  // when the DUT samples on the rising edge. An accepted read is answered
  // one full cycle later.
  always @(negedge clock) begin
    if (reset_n && avm_waitrequest && !(avm_read === 1'b1 && avm_address === 1'b0))
      stall_bad++;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'h0;
    if (!reset_n) begin
      rsp_due   = 1'b0;
      stall_cnt = 0;
    end else begin
      if (stray_req != stray_done) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        stray_done        = stray_req;
      end else if (rsp_due) begin
        rsp_due = 1'b0;
        if (rsp_addr ? ts_rsp_en : id_rsp_en) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rsp_addr ? ts_data : id_data;
        end
      end
      if (avm_read === 1'b1) begin
        if (avm_address === 1'b0 && stall_cnt < stall_id) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
          stall_seen++;
        end else begin
          stall_cnt = 0;
          rsp_due   = 1'b1;
          rsp_addr  = avm_address;
          if (avm_address) ts_accepts++;
          else id_accepts++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    check(tag, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc;
    int id0, ts0, st0, sb0;

    // ---------------- reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_read",   {31'h0, avm_read},    32'h0);
    check("rst_addr",   {31'h0, avm_address}, 32'h0);
    check("rst_busy",   {31'h0, busy},        32'h0);
    check("rst_done",   {31'h0, done},        32'h0);
    check("rst_match",  {31'h0, match},       32'h0);
    check("rst_tmo",    {31'h0, timeout},     32'h0);
    check("rst_sysid",  sysid_value,          32'h0);
    check("rst_ts",     timestamp_value,      32'h0);

    // ---------------- auto-check after release, zero-wait slave
    @(negedge clock);
    #1 reset_n = 1'b1;
    wait_done("auto_done", 10, cyc);
    check("auto_latency", 32'(cyc),           32'd5);
    check("auto_match",   {31'h0, match},     32'h1);
    check("auto_tmo",     {31'h0, timeout},   32'h0);
    check("auto_busy",    {31'h0, busy},      32'h0);
    check("auto_sysid",   sysid_value,        32'h0);
    check("auto_ts",      timestamp_value,    TS_GOOD);
    check("auto_id_acc",  32'(id_accepts),    32'd1);
    check("auto_ts_acc",  32'(ts_accepts),    32'd1);

    // ---------------- waitrequest held for 5 cycles on the ID read
    id0 = id_accepts; ts0 = ts_accepts; st0 = stall_seen; sb0 = stall_bad;
    stall_id = 5;
    pulse_start();
    check("stall_done_clr", {31'h0, done},  32'h0);
    check("stall_busy",     {31'h0, busy},  32'h1);
    wait_done("stall_done", 20, cyc);
    stall_id = 0;
    check("stall_latency",  32'(cyc),                32'd9);
    check("stall_cycles",   32'(stall_seen - st0),   32'd5);
    check("stall_stable",   32'(stall_bad - sb0),    32'd0);
    check("stall_id_acc",   32'(id_accepts - id0),   32'd1);
    check("stall_ts_acc",   32'(ts_accepts - ts0),   32'd1);
    check("stall_match",    {31'h0, match},          32'h1);

    // ---------------- wrong timestamp
    ts_data = 32'h0000_0001;
    pulse_start();
    wait_done("badts_done", 10, cyc);
    check("badts_latency", 32'(cyc),         32'd4);
    check("badts_match",   {31'h0, match},   32'h0);
    check("badts_ts",      timestamp_value,  32'h0000_0001);
    check("badts_sysid",   sysid_value,      32'h0);
    ts_data = TS_GOOD;

    // ---------------- start while busy is ignored
    id0 = id_accepts; ts0 = ts_accepts;
    pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_start_read", {31'h0, avm_read}, 32'h0);
    check("busy_start_busy", {31'h0, busy},     32'h1);
    wait_done("busy_start_done", 10, cyc);
    check("busy_start_lat",  32'(cyc),              32'd3);
    check("busy_start_id",   32'(id_accepts - id0), 32'd1);
    check("busy_start_ts",   32'(ts_accepts - ts0), 32'd1);
    check("busy_start_match", {31'h0, match},       32'h1);

    // ---------------- reset during RSP_TS, stray readdatavalid afterwards
    ts_rsp_en = 1'b0;
    pulse_start();
    repeat (3) @(negedge clock);
    check("rsp_ts_busy", {31'h0, busy},        32'h1);
    check("rsp_ts_addr", {31'h0, avm_address}, 32'h1);
    check("rsp_ts_read", {31'h0, avm_read},    32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_read",  {31'h0, avm_read},    32'h0);
    check("midrst_addr",  {31'h0, avm_address}, 32'h0);
    check("midrst_busy",  {31'h0, busy},        32'h0);
    check("midrst_done",  {31'h0, done},        32'h0);
    check("midrst_match", {31'h0, match},       32'h0);
    check("midrst_tmo",   {31'h0, timeout},     32'h0);
    check("midrst_ts",    timestamp_value,      32'h0);
    check("midrst_sysid", sysid_value,          32'h0);
    stray_req = stray_req + 1;
    ts_rsp_en = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("stray_idle_busy", {31'h0, busy}, 32'h0);
    @(negedge clock);
    check("stray_sysid",   sysid_value,          32'h0);
    check("stray_busy",    {31'h0, busy},        32'h1);
    check("stray_read",    {31'h0, avm_read},    32'h1);
    check("stray_addr",    {31'h0, avm_address}, 32'h0);
    wait_done("rerun_done", 10, cyc);
    check("rerun_latency", 32'(cyc),        32'd4);
    check("rerun_match",   {31'h0, match},  32'h1);
    check("rerun_ts",      timestamp_value, TS_GOOD);

`ifdef SYSID_CHECK_TIMEOUT_EN
    // ---------------- watchdog: no response to the ID read
    id_rsp_en = 1'b0;
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("tmo_latency", 32'(cyc),          32'd9);
    check("tmo_done",    {31'h0, done},     32'h1);
    check("tmo_flag",    {31'h0, timeout},  32'h1);
    check("tmo_match",   {31'h0, match},    32'h0);
    check("tmo_read",    {31'h0, avm_read}, 32'h0);
    check("tmo_busy",    {31'h0, busy},     32'h0);
    id_rsp_en = 1'b1;
    pulse_start();
    check("tmo_clr",      {31'h0, timeout},     32'h0);
    check("tmo_re_done",  {31'h0, done},        32'h0);
    check("tmo_re_read",  {31'h0, avm_read},    32'h1);
    check("tmo_re_addr",  {31'h0, avm_address}, 32'h0);
    wait_done("tmo_re_finish", 10, cyc);
    check("tmo_re_match", {31'h0, match},   32'h1);
    check("tmo_re_flag",  {31'h0, timeout}, 32'h0);
`else
    // ---------------- no watchdog: a missing response is waited on forever
    id_rsp_en = 1'b0;
    pulse_start();
    repeat (40) @(negedge clock);
    check("wait_tmo",  {31'h0, timeout},  32'h0);
    check("wait_busy", {31'h0, busy},     32'h1);
    check("wait_done", {31'h0, done},     32'h0);
    check("wait_read", {31'h0, avm_read}, 32'h0);
    id_rsp_en = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b1;
    wait_done("wait_re_finish", 10, cyc);
    check("wait_re_latency", 32'(cyc),       32'd5);
    check("wait_re_match",   {31'h0, match}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_checker.md
NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000: system ID value the hardware must report.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1478524007: build timestamp the hardware must report.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: per-phase watchdog limit.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse requesting a new check.
REQ-007 avm_address  output  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_readdata  input  32  Avalon-MM read data.
REQ-010 avm_waitrequest  input  1  slave stall; command accepted when avm_read=1 and avm_waitrequest=0.
REQ-011 avm_readdatavalid  input  1  avm_readdata valid this cycle.
REQ-012 sysid_value  output  32  captured ID word.
REQ-013 timestamp_value  output  32  captured timestamp word.
REQ-014 busy  output  1  check in progress.
REQ-015 done  output  1  sticky; check finished.
REQ-016 match  output  1  both words equal their expected values; valid when done=1.
REQ-017 timeout  output  1  sticky; check aborted by watchdog.

Function
REQ-018 FSM states SHALL be IDLE, REQ_ID, RSP_ID, REQ_TS, RSP_TS, DONE; busy=1 exactly in the four REQ/RSP states.
REQ-019 After reset release the FSM SHALL leave IDLE for REQ_ID on the first clock edge without waiting for start (auto-check).
REQ-020 In REQ_ID: avm_read=1, avm_address=0, held stable until acceptance; on acceptance the next state SHALL be RSP_ID with avm_read=0 in that cycle.
REQ-021 In RSP_ID: the first cycle with avm_readdatavalid=1 SHALL load sysid_value from avm_readdata and move to REQ_TS.
REQ-022 REQ_TS/RSP_TS SHALL behave as REQ_ID/RSP_ID with avm_address=1, loading timestamp_value, then move to DONE.
REQ-023 On entering DONE: done=1; match=1 iff sysid_value==EXPECTED_ID and timestamp_value==EXPECTED_TIMESTAMP, else 0.
REQ-024 At most one read SHALL be outstanding; avm_readdatavalid SHALL be ignored in IDLE, REQ_*, and DONE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start in DONE or IDLE SHALL clear done, match and timeout and enter REQ_ID on the next edge; sysid_value/timestamp_value retain old values until overwritten.
REQ-027 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, match=0, timeout=0, sysid_value=0, timestamp_value=0, watchdog count=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately; a late avm_readdatavalid after release SHALL be ignored per REQ-024.

Configuration
REQ-030 Macro SYSID_CHECK_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to each REQ/RSP state, increment each cycle in it, and on reaching TIMEOUT_CYCLES force DONE with timeout=1, match=0, avm_read=0.
REQ-031 Macro SYSID_CHECK_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be constant 0, and REQ/RSP states SHALL wait indefinitely.

Verification
REQ-032 Reset release, slave zero-wait, readdatavalid 1 cycle after accept returning 0 then 1478524007 -> done=1, match=1, timeout=0 within 6 cycles; sysid_value=0, timestamp_value=1478524007.
REQ-033 waitrequest held high 5 cycles on ID read -> avm_read/avm_address stable all 5 cycles, exactly one accepted command, final match=1.
REQ-034 Timestamp returned as 32'h0000_0001 -> done=1, match=0, timestamp_value=1.
REQ-035 With SYSID_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=8, readdatavalid never asserted -> timeout=1, done=1, match=0, avm_read=0 after 8 cycles in RSP_ID; start pulse clears timeout and reissues address 0.
REQ-036 start pulsed while busy, plus reset_n pulsed low during RSP_TS -> start ignored; all outputs zero during reset; fresh auto-check completes with match=1.
